// File: rtl/udp_reg_ring_master.sv
// Ring initiator: one core register access at a time becomes one ring request; the matching return completes it.
// Ack comes ring delay + 3 cycles after core_reg_req; requests while busy are dropped, a lost request times out.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_ring_master #(
  parameter int                           UDP_REG_SRC_WIDTH = 2,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = '0,
  parameter int                           TIMEOUT           = 200,
  parameter int                           TIMEOUT_BITS      = 8,
  parameter logic [`CPCI_NF2_DATA_WIDTH-1:0] UNACK_DATA     = 32'hDEAD_BEEF,
  parameter logic [`CPCI_NF2_DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_0001
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            core_reg_req,
  input  logic                            core_reg_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data,
  output logic                            core_reg_ack,
  output logic                            core_reg_err,
  output logic                            core_reg_busy,
  output logic                            reg_req_out,
  output logic                            reg_ack_out,
  output logic                            reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out,
  input  logic                            reg_req_in,
  input  logic                            reg_ack_in,
  input  logic                            reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in
);

  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam logic [TIMEOUT_BITS-1:0] TIMER_LAST = TIMEOUT_BITS'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state;
  logic                    rd_wr_l_q;
  logic [AW-1:0]           addr_q;
  logic [DW-1:0]           wr_data_q;
  logic [TIMEOUT_BITS-1:0] timer;
  logic                    ring_match;
  logic                    unused_ring;

  // Only our own tag completes a transaction; everything else at the tail is sunk.
  assign ring_match  = reg_req_in && (reg_src_in == SRC_ID);
  assign unused_ring = ^{reg_rd_wr_L_in, reg_addr_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      rd_wr_l_q        <= 1'b0;
      addr_q           <= '0;
      wr_data_q        <= '0;
      timer            <= '0;
      core_reg_rd_data <= '0;
      core_reg_ack     <= 1'b0;
      core_reg_err     <= 1'b0;
      core_reg_busy    <= 1'b0;
      reg_req_out      <= 1'b0;
      reg_ack_out      <= 1'b0;
      reg_rd_wr_L_out  <= 1'b0;
      reg_addr_out     <= '0;
      reg_data_out     <= '0;
      reg_src_out      <= '0;
    end else begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      core_reg_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (core_reg_req) begin
            rd_wr_l_q     <= core_reg_rd_wr_L;
            addr_q        <= core_reg_addr;
            wr_data_q     <= core_reg_wr_data;
            core_reg_busy <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          reg_req_out     <= 1'b1;
          reg_rd_wr_L_out <= rd_wr_l_q;
          reg_addr_out    <= addr_q;
          reg_data_out    <= rd_wr_l_q ? '0 : wr_data_q;
          reg_src_out     <= SRC_ID;
          timer           <= '0;
          state           <= WAIT;
        end
        WAIT: begin
          // A return in the final timer cycle still counts as a normal completion.
          if (ring_match) begin
            core_reg_ack     <= 1'b1;
            core_reg_rd_data <= reg_ack_in ? reg_data_in : UNACK_DATA;
            core_reg_err     <= ~reg_ack_in;
            state            <= DONE;
          end else if (timer == TIMER_LAST) begin
            core_reg_ack     <= 1'b1;
            core_reg_rd_data <= TIMEOUT_DATA;
            core_reg_err     <= 1'b1;
            state            <= DONE;
          end else begin
            timer <= timer + TIMEOUT_BITS'(1);
          end
        end
        DONE: begin
          core_reg_busy    <= 1'b0;
          core_reg_rd_data <= '0;
          core_reg_err     <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Directed bench for udp_reg_ring_master: table of single transactions plus hand-built corner sequences.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_ring_master;
  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam logic [1:0] SRC     = 2'd1;
  localparam logic [1:0] FOREIGN = 2'd2;
  localparam int TMO = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          core_reg_req, core_reg_rd_wr_L;
  logic [AW-1:0] core_reg_addr;
  logic [DW-1:0] core_reg_wr_data, core_reg_rd_data;
  logic          core_reg_ack, core_reg_err, core_reg_busy;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [1:0]    reg_src_out;
  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [DW-1:0] reg_data_in;
  logic [1:0]    reg_src_in;

  udp_reg_ring_master #(
    .UDP_REG_SRC_WIDTH(2), .SRC_ID(SRC), .TIMEOUT(TMO), .TIMEOUT_BITS(8),
    .UNACK_DATA(32'hDEAD_BEEF), .TIMEOUT_DATA(32'hDEAD_0001)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
    .core_reg_rd_data(core_reg_rd_data), .core_reg_ack(core_reg_ack),
    .core_reg_err(core_reg_err), .core_reg_busy(core_reg_busy),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Results of the most recent run() call; cycle 0 is the cycle core_reg_req is first high.
  int            r_pulses, r_pcyc, r_acks, r_ackcyc;
  logic          r_rw, r_ackout, r_err, r_busy_first, r_busy_ack, r_busy_end;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data, r_rd;
  logic [1:0]    r_src;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            delay;
    bit            drop;
    logic          rack;
    logic [DW-1:0] rdata;
    int            exp_lat;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ring();
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  task automatic run(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input int delay, input bit drop, input logic rack, input logic [DW-1:0] rdata,
                     input int foreign_cyc, input int req_hold, input int ncyc);
    int ret_cyc;
    ret_cyc = -1;
    r_pulses = 0; r_pcyc = -1; r_acks = 0; r_ackcyc = -1;
    r_rw = 1'b0; r_ackout = 1'b0; r_addr = '0; r_data = '0; r_src = '0;
    r_rd = '0; r_err = 1'b0; r_busy_first = 1'b0; r_busy_ack = 1'b0;
    core_reg_req = 1'b1; core_reg_rd_wr_L = rw; core_reg_addr = addr; core_reg_wr_data = wd;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      core_reg_req = (c < req_hold);
      clear_ring();
      if (c == 1) r_busy_first = core_reg_busy;
      if (reg_req_out) begin
        r_pulses++;
        if (r_pulses == 1) begin
          r_pcyc = c; r_rw = reg_rd_wr_L_out; r_addr = reg_addr_out;
          r_data = reg_data_out; r_src = reg_src_out; r_ackout = reg_ack_out;
          if (!drop) ret_cyc = c + delay;
        end
      end
      if (c == foreign_cyc) begin
        reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_src_in = FOREIGN; reg_data_in = 32'hF0F0_F0F0;
      end
      if (c == ret_cyc) begin
        reg_req_in = 1'b1; reg_ack_in = rack; reg_src_in = SRC; reg_data_in = rdata;
        reg_addr_in = r_addr; reg_rd_wr_L_in = r_rw;
      end
      if (core_reg_ack) begin
        r_acks++;
        if (r_acks == 1) begin
          r_ackcyc = c; r_rd = core_reg_rd_data; r_err = core_reg_err; r_busy_ack = core_reg_busy;
        end
      end
    end
    core_reg_req = 1'b0;
    clear_ring();
    r_busy_end = core_reg_busy;
  endtask

  // Watches n cycles and returns how many ack pulses appeared.
  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int c = 0; c < n; c++) begin
      step();
      clear_ring();
      if (core_reg_ack) acks++;
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req_out"}, 32'(reg_req_out), 0);
    chk({nm, "_ack_out"}, 32'(reg_ack_out), 0);
    chk({nm, "_rw_out"},  32'(reg_rd_wr_L_out), 0);
    chk({nm, "_addr_out"}, 32'(reg_addr_out), 0);
    chk({nm, "_data_out"}, reg_data_out, 0);
    chk({nm, "_src_out"}, 32'(reg_src_out), 0);
    chk({nm, "_core_ack"}, 32'(core_reg_ack), 0);
    chk({nm, "_core_err"}, 32'(core_reg_err), 0);
    chk({nm, "_core_busy"}, 32'(core_reg_busy), 0);
    chk({nm, "_core_rd"}, core_reg_rd_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    //          rw    addr          wd             dly drop rack rdata          lat   exp_rd         err
    vt[0] = '{1'b1, 23'h000100, 32'h0,          3,  0,  1'b1, 32'h1234_5678, 6,    32'h1234_5678, 1'b0};
    vt[1] = '{1'b0, 23'h000104, 32'hCAFE_F00D,  3,  0,  1'b1, 32'h5A5A_0104, 6,    32'h5A5A_0104, 1'b0};
    vt[2] = '{1'b1, 23'h000200, 32'h0,          2,  0,  1'b0, 32'h1111_2222, 5,    32'hDEAD_BEEF, 1'b1};
    vt[3] = '{1'b1, 23'h7FFFFF, 32'h0,          0,  0,  1'b1, 32'hA5A5_A5A5, 3,    32'hA5A5_A5A5, 1'b0};
    vt[4] = '{1'b0, 23'h000108, 32'h0BAD_C0DE,  9,  0,  1'b1, 32'h0000_0042, 12,   32'h0000_0042, 1'b0};
    vt[5] = '{1'b1, 23'h000300, 32'h0,          0,  1,  1'b1, 32'h0,         TMO+2, 32'hDEAD_0001, 1'b1};

    reset_n = 1'b0;
    core_reg_req = 1'b0; core_reg_rd_wr_L = 1'b0; core_reg_addr = '0; core_reg_wr_data = '0;
    clear_ring();
    step(); step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run(vt[i].rw, vt[i].addr, vt[i].wd, vt[i].delay, vt[i].drop, vt[i].rack, vt[i].rdata,
          -1, 1, vt[i].exp_lat + 3);
      chk($sformatf("v%0d_pulses", i), r_pulses, 1);
      chk($sformatf("v%0d_pulse_cyc", i), r_pcyc, 2);
      chk($sformatf("v%0d_head_rw", i), 32'(r_rw), 32'(vt[i].rw));
      chk($sformatf("v%0d_head_addr", i), 32'(r_addr), 32'(vt[i].addr));
      chk($sformatf("v%0d_head_data", i), r_data, vt[i].rw ? 32'h0 : vt[i].wd);
      chk($sformatf("v%0d_head_src", i), 32'(r_src), 32'(SRC));
      chk($sformatf("v%0d_head_ack", i), 32'(r_ackout), 0);
      chk($sformatf("v%0d_acks", i), r_acks, 1);
      chk($sformatf("v%0d_ack_cyc", i), r_ackcyc, vt[i].exp_lat);
      chk($sformatf("v%0d_rd_data", i), r_rd, vt[i].exp_rd);
      chk($sformatf("v%0d_err", i), 32'(r_err), 32'(vt[i].exp_err));
      chk($sformatf("v%0d_busy_first", i), 32'(r_busy_first), 1);
      chk($sformatf("v%0d_busy_at_ack", i), 32'(r_busy_ack), 1);
      chk($sformatf("v%0d_busy_after", i), 32'(r_busy_end), 0);
    end

    // Late return after the timeout above: arrives in IDLE and must not produce an ack.
    reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_src_in = SRC; reg_data_in = 32'h1A7E_0000;
    count_acks(5, acks);
    chk("late_ret_acks", acks, 0);
    chk("late_ret_busy", 32'(core_reg_busy), 0);

    // Foreign-tag return mid-WAIT and core_reg_req held high while busy.
    run(1'b1, 23'h000400, 32'h0, 4, 0, 1'b1, 32'h600D_F00D, 3, 5, 10);
    chk("busy_pulses", r_pulses, 1);
    chk("busy_acks", r_acks, 1);
    chk("foreign_ack_cyc", r_ackcyc, 7);
    chk("foreign_rd_data", r_rd, 32'h600D_F00D);
    chk("foreign_err", 32'(r_err), 0);
    count_acks(4, acks);
    chk("busy_no_extra_req", 32'(reg_req_out), 0);

    // Reset while the request sits on the ring head.
    core_reg_req = 1'b1; core_reg_rd_wr_L = 1'b1; core_reg_addr = 23'h000500;
    step();
    core_reg_req = 1'b0;
    step();
    chk("pre_reset_req_out", 32'(reg_req_out), 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    step();
    reset_n = 1'b1;
    reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_src_in = SRC; reg_data_in = 32'h5717_E000;
    count_acks(6, acks);
    chk("post_reset_acks", acks, 0);
    chk("post_reset_busy", 32'(core_reg_busy), 0);

    run(1'b1, 23'h000100, 32'h0, 3, 0, 1'b1, 32'h8765_4321, -1, 1, 9);
    chk("recover_ack_cyc", r_ackcyc, 6);
    chk("recover_rd_data", r_rd, 32'h8765_4321);
    chk("recover_err", 32'(r_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
